// File: rtl/mini_tensor_cpu_core.sv
// mini_tensor_cpu_core: single-issue 8-bit scalar ALU with a 256x8 register file
// and a 4x4 8-bit matrix-multiply engine over a 32-byte tensor register file.
module mini_tensor_cpu_core #(
    parameter int NUM_REGS   = 256,
    parameter int MMA_CYCLES = 4
) (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic [31:0] current_instruction,
    output logic [7:0]  cpu_output,
    output logic [7:0]  tensor_core_result [0:3][0:3],
    output logic        tensor_busy
);

    localparam logic [7:0] OP_ADD = 8'h01;
    localparam logic [7:0] OP_SUB = 8'h02;
    localparam logic [7:0] OP_AND = 8'h03;
    localparam logic [7:0] OP_OR  = 8'h04;
    localparam logic [7:0] OP_MMA = 8'h05;
    localparam logic [7:0] OP_TLI = 8'h06;
    localparam logic [7:0] OP_TMV = 8'h07;
    localparam logic [7:0] OP_XOR = 8'h08;
    localparam logic [7:0] OP_SHL = 8'h09;
    localparam logic [7:0] OP_SHR = 8'h0A;

    localparam logic [1:0] LAST_ROW = 2'(MMA_CYCLES - 1);

    typedef enum logic {
        S_IDLE,
        S_COMPUTE
    } state_t;

    state_t     r_state;
    logic [1:0] r_row;
    logic [7:0] r_regs [0:NUM_REGS-1];
    logic [7:0] r_tens [0:31];
    logic [7:0] r_c    [0:3][0:3];

    logic [7:0] w_rd;
    logic [7:0] w_imm;
    logic [7:0] w_rs2;
    logic [7:0] w_op;
    logic [7:0] w_b;
    logic [7:0] w_tsrc;
    logic [7:0] w_alu;
    logic       w_alu_en;
    logic       w_t_we;
    logic [7:0] w_t_val;
    logic       w_mma_go;
    logic [7:0] w_row  [0:3];
    logic [7:0] w_cfin [0:3][0:3];

    assign w_rd   = current_instruction[31:24];
    assign w_imm  = current_instruction[23:16];
    assign w_rs2  = current_instruction[15:8];
    assign w_op   = current_instruction[7:0];
    assign w_b    = r_regs[w_rs2];
    assign w_tsrc = r_regs[w_imm];

    // Tensor writes and multiply start are only accepted while idle.
    assign w_t_we   = !tensor_busy && (w_op == OP_TLI || w_op == OP_TMV);
    assign w_t_val  = (w_op == OP_TLI) ? w_imm : w_tsrc;
    assign w_mma_go = !tensor_busy && (w_op == OP_MMA);

    // Scalar ALU: literal imm against R[rs2]; non-ALU opcodes write nothing.
    always_comb begin
        w_alu_en = 1'b1;
        w_alu    = 8'h00;
        case (w_op)
            OP_ADD:  w_alu = w_imm + w_b;
            OP_SUB:  w_alu = w_imm - w_b;
            OP_AND:  w_alu = w_imm & w_b;
            OP_OR:   w_alu = w_imm | w_b;
            OP_XOR:  w_alu = w_imm ^ w_b;
            OP_SHL:  w_alu = w_b << w_imm[2:0];
            OP_SHR:  w_alu = w_b >> w_imm[2:0];
            default: w_alu_en = 1'b0;
        endcase
    end

    // One output row of C for the current row; products and sums wrap at 8 bits.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_row[j] = 8'h00;
            for (int k = 0; k < 4; k++) begin
                w_row[j] = w_row[j]
                    + r_tens[{1'b0, r_row, 2'(k)}]
                    * r_tens[{1'b1, 2'(k), 2'(j)}];
            end
        end
    end

    // Complete C as it stands after this cycle's row is folded in.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                w_cfin[i][j] = (2'(i) == r_row) ? w_row[j] : r_c[i][j];
            end
        end
    end

    // CPU register file and registered ALU result.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= 8'h00;
            end
            cpu_output <= 8'h00;
        end else if (w_alu_en) begin
            r_regs[w_rd] <= w_alu;
            cpu_output   <= w_alu;
        end
    end

    // MMA state machine plus tensor register file and result matrix.
    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            r_state     <= S_IDLE;
            r_row       <= 2'd0;
            tensor_busy <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                r_tens[i] <= 8'h00;
            end
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    r_c[i][j]                <= 8'h00;
                    tensor_core_result[i][j] <= 8'h00;
                end
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_mma_go) begin
                        r_state     <= S_COMPUTE;
                        r_row       <= 2'd0;
                        tensor_busy <= 1'b1;
                    end else if (w_t_we) begin
                        r_tens[w_rd[4:0]] <= w_t_val;
                    end
                end
                S_COMPUTE: begin
                    for (int j = 0; j < 4; j++) begin
                        r_c[r_row][j] <= w_row[j];
                    end
                    if (r_row == LAST_ROW) begin
                        for (int i = 0; i < 4; i++) begin
                            for (int j = 0; j < 4; j++) begin
                                r_tens[5'(i * 4 + j)]    <= w_cfin[i][j];
                                tensor_core_result[i][j] <= w_cfin[i][j];
                            end
                        end
                        tensor_busy <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_row <= r_row + 2'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mini_tensor_cpu_core.sv
// tb_mini_tensor_cpu_core: directed vectors with hand-computed expectations
// for the scalar ALU, tensor loads, matrix multiply and asynchronous reset.
module tb_mini_tensor_cpu_core;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic [7:0]  cout;
    logic [7:0]  res [0:3][0:3];
    logic        busy;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mini_tensor_cpu_core dut (
        .clock_in           (clk),
        .reset_in           (rst),
        .current_instruction(instr),
        .cpu_output         (cout),
        .tensor_core_result (res),
        .tensor_busy        (busy)
    );

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic exec(input logic [7:0] rd, input logic [7:0] imm,
                        input logic [7:0] rs2, input logic [7:0] op);
        @(negedge clk);
        instr = {rd, imm, rs2, op};
        @(posedge clk);
        #1;
        instr = 32'h0;
    endtask

    // mode 0: all zero; mode 1: element [i][j] = i*4+j+1
    task automatic chk_res(input string tag, input int mode);
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("%s[%0d][%0d]", tag, i, j), res[i][j],
                    (mode == 0) ? 8'h00 : 8'(i * 4 + j + 1));
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        instr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cout", cout, 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk_res("rst_res", 0);
        @(negedge clk);
        rst = 1'b0;

        // scalar ALU
        exec(8'd3, 8'h05, 8'd0, 8'h01);
        chk("add", cout, 8'h05);
        exec(8'd4, 8'hFF, 8'd3, 8'h01);
        chk("add_wrap", cout, 8'h04);
        exec(8'd1, 8'h02, 8'd3, 8'h02);
        chk("sub", cout, 8'hFD);
        exec(8'd5, 8'h01, 8'd3, 8'h09);
        chk("shl", cout, 8'h0A);
        exec(8'd6, 8'h0C, 8'd5, 8'h03);
        chk("and", cout, 8'h08);
        exec(8'd6, 8'h01, 8'd5, 8'h04);
        chk("or", cout, 8'h0B);
        exec(8'd6, 8'hFF, 8'd5, 8'h08);
        chk("xor", cout, 8'hF5);
        exec(8'd6, 8'h02, 8'd5, 8'h0A);
        chk("shr", cout, 8'h02);
        exec(8'd0, 8'h00, 8'd0, 8'h00);
        chk("nop_hold", cout, 8'h02);
        exec(8'd5, 8'h33, 8'd0, 8'hFF);
        chk("bad_op_hold", cout, 8'h02);
        exec(8'd7, 8'h00, 8'd5, 8'h01);
        chk("bad_op_nowr", cout, 8'h0A);
        exec(8'd7, 8'h00, 8'd1, 8'h01);
        chk("r1_val", cout, 8'hFD);

        // all 0x10 operands: every C element is 4*0x100 mod 256 = 0
        for (int a = 0; a < 32; a++) begin
            exec(8'(a), 8'h10, 8'd0, 8'h06);
        end
        chk("tli_hold", cout, 8'hFD);
        exec(8'd0, 8'd0, 8'd0, 8'h05);
        chk("sat_busy0", 8'(busy), 8'h01);
        for (int c = 1; c < 4; c++) begin
            exec(8'd0, 8'd0, 8'd0, 8'h00);
            chk($sformatf("sat_busy%0d", c), 8'(busy), 8'h01);
        end
        exec(8'd0, 8'd0, 8'd0, 8'h00);
        chk("sat_done", 8'(busy), 8'h00);
        chk_res("mma_sat", 0);

        // A = identity, B[i][j] = i*4+j+1 (B[3][3] via TMV, B[0][0] with rd[7:5] set)
        for (int idx = 0; idx < 16; idx++) begin
            exec(8'(idx), 8'((idx / 4 == idx % 4) ? 1 : 0), 8'd0, 8'h06);
        end
        exec(8'hF0, 8'd1, 8'd0, 8'h06);
        for (int idx = 1; idx < 15; idx++) begin
            exec(8'(16 + idx), 8'(idx + 1), 8'd0, 8'h06);
        end
        exec(8'd9, 8'd16, 8'd0, 8'h01);
        chk("r9_set", cout, 8'h10);
        exec(8'd31, 8'd9, 8'd0, 8'h07);
        chk("tmv_hold", cout, 8'h10);

        exec(8'd0, 8'd0, 8'd0, 8'h05);
        chk("id_busy0", 8'(busy), 8'h01);
        exec(8'd0, 8'd0, 8'd0, 8'h00);
        chk("id_busy1", 8'(busy), 8'h01);
        exec(8'd0, 8'd0, 8'd0, 8'h05);
        chk("id_busy2", 8'(busy), 8'h01);
        exec(8'd0, 8'd0, 8'd0, 8'h00);
        chk("id_busy3", 8'(busy), 8'h01);
        exec(8'd0, 8'd0, 8'd0, 8'h00);
        chk("id_done", 8'(busy), 8'h00);
        chk_res("mma_id", 1);
        exec(8'd0, 8'd0, 8'd0, 8'h00);
        chk("id_idle", 8'(busy), 8'h00);

        // B = identity; A now holds the previous C, so C must equal it again
        for (int idx = 0; idx < 16; idx++) begin
            exec(8'(16 + idx), 8'((idx / 4 == idx % 4) ? 1 : 0), 8'd0, 8'h06);
        end
        exec(8'd0, 8'd0, 8'd0, 8'h05);
        exec(8'h0C, 8'h77, 8'd0, 8'h06);
        chk("ab_busy1", 8'(busy), 8'h01);
        exec(8'h00, 8'h77, 8'd0, 8'h06);
        exec(8'd10, 8'h21, 8'd0, 8'h01);
        chk("add_busy", cout, 8'h21);
        exec(8'd0, 8'd0, 8'd0, 8'h00);
        chk("ab_done", 8'(busy), 8'h00);
        chk_res("a_eq_b", 1);

        // asynchronous reset in the middle of a multiply
        exec(8'd0, 8'd0, 8'd0, 8'h05);
        exec(8'd0, 8'd0, 8'd0, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_busy", 8'(busy), 8'h00);
        chk_res("arst_res", 0);
        chk("arst_cout", cout, 8'h00);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        exec(8'd8, 8'd0, 8'd3, 8'h01);
        chk("arst_r3", cout, 8'h00);
        exec(8'd0, 8'd0, 8'd0, 8'h05);
        chk("z_busy0", 8'(busy), 8'h01);
        repeat (3) exec(8'd0, 8'd0, 8'd0, 8'h00);
        chk("z_busy3", 8'(busy), 8'h01);
        exec(8'd0, 8'd0, 8'd0, 8'h00);
        chk("z_done", 8'(busy), 8'h00);
        chk_res("mma_zero", 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
